// File: rtl/tx_sched_pkg.sv
// Shared symbols and state encoding for the TX link scheduler.
// Ordered-set insertion in the scheduler is enabled by the TX_SCHED_SKP_EN macro.
package tx_sched_pkg;

    localparam logic [7:0] K28_5    = 8'hBC;
    localparam logic [7:0] K28_0    = 8'h1C;
    localparam logic [7:0] IDLE_SYM = 8'h00;

    typedef enum logic [1:0] {
        ST_NORMAL  = 2'd0,
        ST_SKP_COM = 2'd1,
        ST_SKP     = 2'd2
    } tx_state_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: the pointer side wins a tie, and every
// grant taken while advance is high hands priority to the other side.
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic ptr;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    // Granting side 0 leaves side 1 with priority, and vice versa.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= 1'b0;
        end else if (advance && (gnt != 2'b00)) begin
            ptr <= gnt[0];
        end
    end

endmodule

// File: rtl/tx_link_scheduler.sv
// Merges two byte requesters into one symbol stream for an 8b/10b encoder,
// inserting COM+SKP ordered sets when TX_SCHED_SKP_EN is defined.
module tx_link_scheduler
    import tx_sched_pkg::*;
#(
    parameter int SKP_INTERVAL = 16,
    parameter int SKP_LEN      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic [1:0] gnt,
    output logic [7:0] enc_data,
    output logic       enc_k,
    output logic       enc_valid,
    output tx_state_e  state_dbg
);

    // Handshake: requester i holds req[i] high with its byte valid on data<i>;
    // the byte is taken in any cycle with gnt[i]=1, and a fresh byte (or a
    // dropped req) may be presented from the following cycle on.

    if (SKP_INTERVAL < 4 || SKP_INTERVAL > 1023 || SKP_LEN < 1 || SKP_LEN > 5) begin : g_cfg_check
        $error("tx_link_scheduler: SKP_INTERVAL or SKP_LEN out of range");
    end

    tx_state_e  state;
    logic       in_normal;
    logic [1:0] arb_req;
    logic [7:0] slot_data;

`ifdef TX_SCHED_SKP_EN
    localparam logic [9:0] CNT_LAST = 10'(SKP_INTERVAL - 1);
    localparam logic [2:0] SUB_LAST = 3'(SKP_LEN - 1);

    tx_state_e  state_n;
    logic [9:0] cnt;
    logic [9:0] cnt_n;
    logic [2:0] sub;
    logic [2:0] sub_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_NORMAL;
            cnt   <= 10'd0;
            sub   <= 3'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            sub   <= sub_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sub_n   = sub;
        case (state)
            ST_NORMAL: begin
                if (cnt == CNT_LAST) begin
                    state_n = ST_SKP_COM;
                    cnt_n   = 10'd0;
                end else begin
                    cnt_n = cnt + 10'd1;
                end
            end
            ST_SKP_COM: begin
                state_n = ST_SKP;
                sub_n   = 3'd0;
            end
            ST_SKP: begin
                if (sub == SUB_LAST) begin
                    state_n = ST_NORMAL;
                    sub_n   = 3'd0;
                end else begin
                    sub_n = sub + 3'd1;
                end
            end
            default: begin
                state_n = ST_NORMAL;
                cnt_n   = 10'd0;
                sub_n   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enc_k <= 1'b0;
        end else begin
            enc_k <= (state != ST_NORMAL);
        end
    end
`else
    assign state = ST_NORMAL;
    assign enc_k = 1'b0;
`endif

    // Reset gates the request path so gnt drops immediately, not at the next edge.
    assign in_normal = rst && (state == ST_NORMAL);
    assign arb_req   = in_normal ? req : 2'b00;

    rr_arbiter_2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (arb_req),
        .advance (in_normal),
        .gnt     (gnt)
    );

    always_comb begin
        slot_data = IDLE_SYM;
        case (state)
            ST_NORMAL: begin
                if (gnt[0]) begin
                    slot_data = data0;
                end else if (gnt[1]) begin
                    slot_data = data1;
                end else begin
                    slot_data = IDLE_SYM;
                end
            end
            ST_SKP_COM: slot_data = K28_5;
            ST_SKP:     slot_data = K28_0;
            default:    slot_data = IDLE_SYM;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enc_data  <= IDLE_SYM;
            enc_valid <= 1'b0;
        end else begin
            enc_data  <= slot_data;
            enc_valid <= 1'b1;
        end
    end

    assign state_dbg = state;

endmodule
